irq_priority_controller: RTL and testbench

- Parametrised, clocked successor to the combinational 8-input priority resolver.
- Owns the interrupt request register (IRR), in-service register (ISR) and the rotating priority pointer for NUM_IRQ inputs.
- Runs the two-pulse INTA acknowledge handshake and supports non-specific/specific EOI, automatic EOI, automatic and specific rotation, and special mask mode.
- Sits between the IR pins and the bus/cascade control logic; the control logic supplies IMR and mode bits.

---
 rtl/irq_priority_controller.sv | 187 ++++++++++++++++++
 tb/tb_irq_priority_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_controller.sv
// IRQ priority controller: IRR/ISR, rotating priority, two-pulse INTA handshake, EOI handling.
// All outputs registered; int_out rises one cycle after a qualified request is seen in IDLE.
module irq_priority_controller #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               special_mask_mode,
  input  logic               auto_eoi,
  input  logic               auto_rotate,
  input  logic               inta,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [IDX_W-1:0]   eoi_level,
  input  logic               set_prio_valid,
  input  logic [IDX_W-1:0]   set_prio_level,
  output logic               int_out,
  output logic               vector_valid,
  output logic [IDX_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] irr_out,
  output logic [NUM_IRQ-1:0] isr_out
);

  localparam int RW = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IRQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACK1} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ir_prev_q;
  logic [IDX_W-1:0]   low_q, low_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               spur_q, spur_d;
  logic               int_q, int_d;
  logic               vv_q, vv_d;
  logic [IDX_W-1:0]   vec_q, vec_d;

  logic [NUM_IRQ-1:0] cand;
  logic [IDX_W:0]     win_f, isr_top_f;
  logic               qual;
  logic               eoi_hit;
  logic [IDX_W-1:0]   eoi_idx;

  // Scan from the highest-priority slot downward; MSB of result flags "found".
  function automatic logic [IDX_W:0] pick_highest(input logic [NUM_IRQ-1:0] vec,
                                                  input logic [IDX_W-1:0]   low);
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   res;
    res = '0;
    idx = (low == LAST) ? '0 : low + IDX_W'(1);
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (vec[idx] && !res[IDX_W]) res = {1'b1, idx};
      idx = (idx == LAST) ? '0 : idx + IDX_W'(1);
    end
    return res;
  endfunction

  // 0 = highest priority under the current rotation.
  function automatic logic [RW-1:0] rank(input logic [IDX_W-1:0] i,
                                         input logic [IDX_W-1:0] low);
    logic [RW-1:0] r;
    if (i > low) r = {1'b0, i} - {1'b0, low} - RW'(1);
    else         r = {1'b0, i} + RW'(NUM_IRQ) - {1'b0, low} - RW'(1);
    return r;
  endfunction

  always_comb begin
    cand = irr_q & ~imr;
    if (special_mask_mode) cand = cand & ~isr_q;
    win_f     = pick_highest(cand, low_q);
    isr_top_f = pick_highest(isr_q, low_q);
    qual      = 1'b0;
    if (win_f[IDX_W]) begin
      if (special_mask_mode || !isr_top_f[IDX_W]) qual = 1'b1;
      else qual = rank(win_f[IDX_W-1:0], low_q) < rank(isr_top_f[IDX_W-1:0], low_q);
    end
  end

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    vv_d    = 1'b0;
    vec_d   = vec_q;
    sel_d   = sel_q;
    spur_d  = spur_q;
    low_d   = low_q;
    isr_d   = isr_q;
    irr_d   = level_mode ? ir_in : (irr_q | (ir_in & ~ir_prev_q));
    eoi_hit = 1'b0;
    eoi_idx = '0;

    if (eoi_valid) begin
      if (eoi_specific) begin
        if (({1'b0, eoi_level} < RW'(NUM_IRQ)) && isr_q[eoi_level]) begin
          eoi_hit = 1'b1;
          eoi_idx = eoi_level;
        end
      end else begin
        eoi_hit = isr_top_f[IDX_W];
        eoi_idx = isr_top_f[IDX_W-1:0];
      end
    end
    if (eoi_hit) begin
      isr_d[eoi_idx] = 1'b0;
      if (eoi_rotate) low_d = eoi_idx;
    end

    // ISR set is applied after EOI clears so a same-bit set wins.
    case (state_q)
      ST_IDLE: begin
        if (qual) begin
          int_d   = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (inta) begin
          if (qual) begin
            sel_d                 = win_f[IDX_W-1:0];
            spur_d                = 1'b0;
            isr_d[win_f[IDX_W-1:0]] = 1'b1;
            irr_d[win_f[IDX_W-1:0]] = 1'b0;
          end else begin
            sel_d  = LAST;
            spur_d = 1'b1;
          end
          int_d   = 1'b0;
          state_d = ST_ACK1;
        end
      end
      ST_ACK1: begin
        if (inta) begin
          vv_d  = 1'b1;
          vec_d = sel_q;
          if (auto_eoi && !spur_q) begin
            isr_d[sel_q] = 1'b0;
            if (auto_rotate) low_d = sel_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (set_prio_valid && ({1'b0, set_prio_level} < RW'(NUM_IRQ))) low_d = set_prio_level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      irr_q     <= '0;
      isr_q     <= '0;
      ir_prev_q <= '1;
      low_q     <= LAST;
      sel_q     <= '0;
      spur_q    <= 1'b0;
      int_q     <= 1'b0;
      vv_q      <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_prev_q <= ir_in;
      low_q     <= low_d;
      sel_q     <= sel_d;
      spur_q    <= spur_d;
      int_q     <= int_d;
      vv_q      <= vv_d;
      vec_q     <= vec_d;
    end
  end

  assign int_out      = int_q;
  assign vector_valid = vv_q;
  assign vector       = vec_q;
  assign irr_out      = irr_q;
  assign isr_out      = isr_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Bench for irq_priority_controller (NUM_IRQ=12): rank-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_irq_priority_controller;

  localparam int N  = 12;
  localparam int IW = 4;

  logic          clk, reset_n;
  logic [N-1:0]  ir_in, imr;
  logic          level_mode, special_mask_mode, auto_eoi, auto_rotate, inta;
  logic          eoi_valid, eoi_specific, eoi_rotate, set_prio_valid;
  logic [IW-1:0] eoi_level, set_prio_level;
  logic          int_out, vector_valid;
  logic [IW-1:0] vector;
  logic [N-1:0]  irr_out, isr_out;

  int n_chk  = 0;
  int n_fail = 0;

  irq_priority_controller #(.NUM_IRQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .level_mode(level_mode), .imr(imr),
    .special_mask_mode(special_mask_mode), .auto_eoi(auto_eoi), .auto_rotate(auto_rotate),
    .inta(inta), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate),
    .eoi_level(eoi_level), .set_prio_valid(set_prio_valid), .set_prio_level(set_prio_level),
    .int_out(int_out), .vector_valid(vector_valid), .vector(vector),
    .irr_out(irr_out), .isr_out(isr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: priority expressed as a rank, winner = minimum rank.
  logic [N-1:0] m_irr, m_isr, m_prev;
  int           m_low, m_st, m_sel, m_vec;
  bit           m_spur;
  logic         m_int, m_vv;

  function automatic int mrank(input int i, input int low);
    return (i - low - 1 + 2 * N) % N;
  endfunction

  function automatic int mtop(input logic [N-1:0] v, input int low);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (best < 0 || mrank(i, low) < mrank(best, low))) best = i;
    return best;
  endfunction

  task automatic m_reset();
    m_irr = '0; m_isr = '0; m_prev = '1; m_low = N - 1; m_st = 0;
    m_sel = 0; m_spur = 0; m_int = 0; m_vv = 0; m_vec = 0;
  endtask

  task automatic m_step();
    logic [N-1:0] cand, nirr, nisr;
    int w, t, c, nlow;
    bit q;
    cand = m_irr & ~imr;
    if (special_mask_mode) cand = cand & ~m_isr;
    w = mtop(cand, m_low);
    t = mtop(m_isr, m_low);
    q = (w >= 0) && (special_mask_mode || t < 0 || mrank(w, m_low) < mrank(t, m_low));
    nirr = level_mode ? ir_in : (m_irr | (ir_in & ~m_prev));
    nisr = m_isr;
    nlow = m_low;
    m_vv = 1'b0;
    if (eoi_valid) begin
      if (eoi_specific) c = (int'(eoi_level) < N && m_isr[eoi_level]) ? int'(eoi_level) : -1;
      else c = t;
      if (c >= 0) begin
        nisr[c] = 1'b0;
        if (eoi_rotate) nlow = c;
      end
    end
    case (m_st)
      0: if (q) begin m_int = 1'b1; m_st = 1; end
      1: if (inta) begin
        if (q) begin m_sel = w; m_spur = 0; nisr[w] = 1'b1; nirr[w] = 1'b0; end
        else begin m_sel = N - 1; m_spur = 1; end
        m_int = 1'b0;
        m_st  = 2;
      end
      default: if (inta) begin
        m_vv  = 1'b1;
        m_vec = m_sel;
        if (auto_eoi && !m_spur) begin
          nisr[m_sel] = 1'b0;
          if (auto_rotate) nlow = m_sel;
        end
        m_st = 0;
      end
    endcase
    if (set_prio_valid && int'(set_prio_level) < N) nlow = int'(set_prio_level);
    m_irr = nirr; m_isr = nisr; m_low = nlow; m_prev = ir_in;
  endtask

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      chk("cyc_irr", irr_out, m_irr);
      chk("cyc_isr", isr_out, m_isr);
      chk("cyc_int", int_out, m_int);
      chk("cyc_vv", vector_valid, m_vv);
      chk("cyc_vec", vector, 64'(m_vec));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ir(input logic [N-1:0] v);
    ir_in = v; cyc(); ir_in = '0;
  endtask

  task automatic wait_int();
    int k = 0;
    while (int_out !== 1'b1 && k < 20) begin cyc(); k++; end
    chk("int_out_rise", int_out, 1);
  endtask

  task automatic ack(input int exp_vec);
    wait_int();
    inta = 1'b1; cyc(); inta = 1'b0; cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    chk("ack_vv", vector_valid, 1);
    chk("ack_vector", vector, exp_vec);
  endtask

  task automatic eoi(input bit spec, input bit rot, input int lvl);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_level = IW'(lvl);
    cyc();
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = '0;
  endtask

  task automatic set_prio(input int lvl);
    set_prio_valid = 1'b1; set_prio_level = IW'(lvl);
    cyc();
    set_prio_valid = 1'b0; set_prio_level = '0;
  endtask

  initial begin : stimulus
    reset_n = 1'b0; ir_in = '0; imr = '0; level_mode = 0; special_mask_mode = 0;
    auto_eoi = 0; auto_rotate = 0; inta = 0; eoi_valid = 0; eoi_specific = 0;
    eoi_rotate = 0; eoi_level = '0; set_prio_valid = 0; set_prio_level = '0;
    cyc(3);
    chk("rst_irr", irr_out, 0); chk("rst_isr", isr_out, 0);
    chk("rst_int", int_out, 0); chk("rst_vv", vector_valid, 0); chk("rst_vec", vector, 0);
    reset_n = 1'b1;
    cyc();

    // Edge-triggered single request, full handshake
    ir_in = 12'h008; cyc(); ir_in = '0;
    chk("t1_irr", irr_out, 12'h008);
    cyc();
    chk("t1_int", int_out, 1);
    inta = 1'b1; cyc(); inta = 1'b0;
    chk("t1_isr", isr_out, 12'h008); chk("t1_irr_clr", irr_out, 0); chk("t1_int_low", int_out, 0);
    inta = 1'b1; cyc(); inta = 1'b0;
    chk("t1_vv", vector_valid, 1); chk("t1_vec", vector, 3);
    eoi(0, 0, 0);
    chk("t1_eoi", isr_out, 0);

    // Nesting: IR5 in service, IR2 preempts, IR6 blocked
    pulse_ir(12'h020); ack(5);
    chk("t2_isr5", isr_out, 12'h020);
    pulse_ir(12'h044); ack(2);
    chk("t2_isr", isr_out, 12'h024);
    cyc(3);
    chk("t2_blocked_int", int_out, 0); chk("t2_irr6", irr_out, 12'h040);
    eoi(0, 0, 0);
    chk("t2_eoi", isr_out, 12'h020);
    cyc(3);
    chk("t2_still_blocked", int_out, 0);
    eoi(0, 0, 0); ack(6); eoi(0, 0, 0);

    // Special mask mode lets a lower level nest; out-of-range specific EOI ignored
    pulse_ir(12'h020); ack(5);
    special_mask_mode = 1'b1;
    pulse_ir(12'h040); ack(6);
    chk("smm_isr", isr_out, 12'h060);
    eoi(1, 0, 13);
    chk("smm_eoi_oor", isr_out, 12'h060);
    eoi(1, 0, 6); eoi(1, 0, 5);
    chk("smm_clear", isr_out, 0);
    special_mask_mode = 1'b0;

    // Specific EOI with rotation: lowest becomes 4, order 5, 0, 4
    pulse_ir(12'h010); ack(4); eoi(1, 1, 4);
    chk("t3_isr", isr_out, 0);
    pulse_ir(12'h031);
    ack(5); eoi(0, 0, 0);
    ack(0); eoi(0, 0, 0);
    ack(4); eoi(0, 0, 0);

    // Level mode with auto EOI + auto rotate alternates 1, 2, 1, 2
    level_mode = 1'b1; auto_eoi = 1'b1; auto_rotate = 1'b1; ir_in = 12'h006;
    ack(1); chk("t4_isr_a", isr_out, 0);
    ack(2); chk("t4_isr_b", isr_out, 0);
    ack(1); ack(2); chk("t4_isr_c", isr_out, 0);
    // Level drops while the next request is already pending: spurious acknowledge
    ir_in = '0;
    cyc();
    chk("t4_int_held", int_out, 1);
    ack(N - 1);
    chk("t4_spur_isr", isr_out, 0);
    level_mode = 1'b0; auto_eoi = 1'b0; auto_rotate = 1'b0;

    // Masked after int_out: int_out held, spurious vector, then real service when unmasked
    pulse_ir(12'h080); wait_int();
    imr = 12'h080;
    cyc(3);
    chk("t5_int_held", int_out, 1);
    ack(N - 1);
    chk("t5_isr", isr_out, 0); chk("t5_irr_kept", irr_out, 12'h080);
    imr = '0;
    ack(7);
    chk("t5_isr7", isr_out, 12'h080);
    eoi(0, 0, 0);

    // Specific rotation, out-of-range level ignored, wrap at non-power-of-2 size
    set_prio(5); set_prio(13);
    pulse_ir(12'h041);
    ack(6); eoi(0, 0, 0); ack(0); eoi(0, 0, 0);
    set_prio(11);
    pulse_ir(12'h801);
    ack(0); eoi(0, 0, 0); ack(11); eoi(0, 0, 0);

    // Reset between INTA pulses abandons the acknowledge
    pulse_ir(12'h008); wait_int();
    inta = 1'b1; cyc(); inta = 1'b0;
    chk("t7_isr", isr_out, 12'h008);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_isr", isr_out, 0); chk("t7_rst_int", int_out, 0);
    inta = 1'b1;
    cyc();
    chk("t7_rst_irr", irr_out, 0); chk("t7_rst_vv", vector_valid, 0);
    reset_n = 1'b1;
    cyc();
    inta = 1'b0;
    cyc(2);
    chk("t7_no_vv", vector_valid, 0); chk("t7_no_int", int_out, 0); chk("t7_vec", vector, 0);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
